nand_op_sequencer: RTL and testbench

//  Time-multiplexes one WIDTH-bit bitwise NAND unit to evaluate NOT/AND/OR/NOR/XOR/XNOR of two operands.

---
 rtl/nand_seq_pkg.sv | 71 +++++++
 rtl/nand_op_sequencer_if.sv | 27 ++
 rtl/nand_unit.sv | 12 +
 rtl/nand_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_nand_op_sequencer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/nand_seq_pkg.sv
// Shared definitions for the NAND op sequencer: opcodes, micro-op operand/destination
// encodings, per-op step counts and the micro-program ROM.
package nand_seq_pkg;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {StIdle, StExec, StErr} state_e;

    typedef enum logic [2:0] {SelA, SelB, SelS0, SelS1, SelS2} sel_e;

    typedef enum logic [1:0] {DstS0, DstS1, DstS2, DstY} dst_e;

    typedef struct packed {
        sel_e selx;
        sel_e sely;
        dst_e dst;
        logic last;
    } uop_t;

    // Number of NAND steps (and cycles of latency) for each legal op.
    function automatic logic [2:0] op_steps(input logic [2:0] op);
        case (op)
            OP_NOT:  return 3'd1;
            OP_AND:  return 3'd2;
            OP_OR:   return 3'd3;
            OP_NOR:  return 3'd4;
            OP_XOR:  return 3'd4;
            OP_XNOR: return 3'd5;
            default: return 3'd1;
        endcase
    endfunction

    function automatic uop_t mk_uop(input sel_e x, input sel_e y, input dst_e d);
        return '{selx: x, sely: y, dst: d, last: 1'b0};
    endfunction

    // Micro-program ROM: {op, step} -> operand selects and destination.
    function automatic uop_t uop_rom(input logic [2:0] op, input logic [2:0] step);
        uop_t u;
        case ({op, step})
            {OP_NOT,  3'd0}: u = mk_uop(SelA,  SelA,  DstY);
            {OP_AND,  3'd0}: u = mk_uop(SelA,  SelB,  DstS0);
            {OP_AND,  3'd1}: u = mk_uop(SelS0, SelS0, DstY);
            {OP_OR,   3'd0}: u = mk_uop(SelA,  SelA,  DstS0);
            {OP_OR,   3'd1}: u = mk_uop(SelB,  SelB,  DstS1);
            {OP_OR,   3'd2}: u = mk_uop(SelS0, SelS1, DstY);
            {OP_NOR,  3'd0}: u = mk_uop(SelA,  SelA,  DstS0);
            {OP_NOR,  3'd1}: u = mk_uop(SelB,  SelB,  DstS1);
            {OP_NOR,  3'd2}: u = mk_uop(SelS0, SelS1, DstS2);
            {OP_NOR,  3'd3}: u = mk_uop(SelS2, SelS2, DstY);
            {OP_XOR,  3'd0}: u = mk_uop(SelA,  SelB,  DstS0);
            {OP_XOR,  3'd1}: u = mk_uop(SelS0, SelA,  DstS1);
            {OP_XOR,  3'd2}: u = mk_uop(SelS0, SelB,  DstS2);
            {OP_XOR,  3'd3}: u = mk_uop(SelS1, SelS2, DstY);
            {OP_XNOR, 3'd0}: u = mk_uop(SelA,  SelB,  DstS0);
            {OP_XNOR, 3'd1}: u = mk_uop(SelS0, SelA,  DstS1);
            {OP_XNOR, 3'd2}: u = mk_uop(SelS0, SelB,  DstS2);
            {OP_XNOR, 3'd3}: u = mk_uop(SelS1, SelS2, DstS0);
            {OP_XNOR, 3'd4}: u = mk_uop(SelS0, SelS0, DstY);
            default:         u = mk_uop(SelA,  SelA,  DstY);
        endcase
        u.last = (step == op_steps(op) - 3'd1);
        return u;
    endfunction

endpackage

// File: rtl/nand_op_sequencer_if.sv
// Requester-side bundle of the NAND op sequencer.
//   start/op/a/b : request (requester drives)
//   busy/done/err/y/nand_cnt : status and result (sequencer drives)
interface nand_op_sequencer_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] nand_cnt;

    modport master (
        output start, op, a, b,
        input  busy, done, err, y, nand_cnt
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, err, y, nand_cnt
    );
endinterface

// File: rtl/nand_unit.sv
// Shared WIDTH-bit bitwise NAND stage (combinational).
//   x, y : operands
//   z    : ~(x & y)
module nand_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z
);
    assign z = ~(x & y);
endmodule

// File: rtl/nand_op_sequencer.sv
// Evaluates NOT/AND/OR/NOR/XOR/XNOR by stepping one NAND unit through a per-op
// micro-program, keeping intermediates in three scratch registers.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of nand_op_sequencer_if (start/op/a/b in; busy/done/err/y/nand_cnt out)
// WIDTH and CNT_W must match the parameters of the connected interface.
module nand_op_sequencer
    import nand_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    nand_op_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d, err_q, err_d;

    uop_t             uop;
    logic [WIDTH-1:0] opx, opy, nz;

    function automatic logic [WIDTH-1:0] pick(input sel_e s, input logic [WIDTH-1:0] av,
                                              input logic [WIDTH-1:0] bv,
                                              input logic [WIDTH-1:0] r0,
                                              input logic [WIDTH-1:0] r1,
                                              input logic [WIDTH-1:0] r2);
        case (s)
            SelA:    return av;
            SelB:    return bv;
            SelS0:   return r0;
            SelS1:   return r1;
            SelS2:   return r2;
            default: return av;
        endcase
    endfunction

    always_comb begin
        uop = uop_rom(op_q, step_q);
        opx = pick(uop.selx, a_q, b_q, s0_q, s1_q, s2_q);
        opy = pick(uop.sely, a_q, b_q, s0_q, s1_q, s2_q);
    end

    nand_unit #(.WIDTH(WIDTH)) u_nand (
        .x (opx),
        .y (opy),
        .z (nz)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // start is only looked at here, so requests while busy are dropped.
                if (bus.start) begin
                    if (bus.op <= OP_XNOR) begin
                        state_d = StExec;
                        op_d    = bus.op;
                        a_d     = bus.a;
                        b_d     = bus.b;
                        step_d  = 3'd0;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StExec: begin
                unique case (uop.dst)
                    DstS0: s0_d = nz;
                    DstS1: s1_d = nz;
                    DstS2: s2_d = nz;
                    DstY:  y_d  = nz;
                endcase
                step_d = step_q + 3'd1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CntOne;
                end
                if (uop.last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StErr: begin
                state_d = StIdle;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= 3'd0;
            op_q    <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.y        = y_q;
    assign bus.nand_cnt = cnt_q;

endmodule

// File: tb/tb_nand_op_sequencer.sv
module tb_nand_op_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nand_op_sequencer_if #(.WIDTH(4), .CNT_W(16)) bus ();

    nand_op_sequencer #(.WIDTH(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [2:0] o, input logic [3:0] av,
                                          input logic [3:0] bv);
        case (o)
            3'd0:    return ~av;
            3'd1:    return av & bv;
            3'd2:    return av | bv;
            3'd3:    return ~(av | bv);
            3'd4:    return av ^ bv;
            default: return ~(av ^ bv);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle (or timeout).
    task automatic run_op(input logic [2:0] o, input logic [3:0] av, input logic [3:0] bv,
                          output int lat);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 4'h0;
        bus.b     = 4'h0;
        lat = 0;
        while (!bus.done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    logic [3:0] exp_y  [6] = '{4'b1100, 4'b0001, 4'b0111, 4'b1000, 4'b0110, 4'b1001};
    int         exp_lat[6] = '{1, 2, 3, 4, 4, 5};

    initial begin
        int lat;
        int pulses;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 4'h0;
        bus.b     = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_y", bus.y, 0);
        check("rst_cnt", bus.nand_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed ops on a=0011, b=0101.
        for (int i = 0; i < 6; i++) begin
            run_op(3'(i), 4'b0011, 4'b0101, lat);
            check($sformatf("op%0d_lat", i), lat, exp_lat[i]);
            check($sformatf("op%0d_y", i), bus.y, exp_y[i]);
            check($sformatf("op%0d_err", i), bus.err, 0);
            check($sformatf("op%0d_busy", i), bus.busy, 0);
            @(negedge clk);
        end
        check("cnt_after_six", bus.nand_cnt, 19);

        // Illegal opcode.
        bus.start = 1'b1;
        bus.op    = 3'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("ill_busy", bus.busy, 1);
        check("ill_done_early", bus.done, 0);
        @(negedge clk);
        check("ill_done", bus.done, 1);
        check("ill_err", bus.err, 1);
        check("ill_busy_off", bus.busy, 0);
        check("ill_y", bus.y, 4'b1001);
        check("ill_cnt", bus.nand_cnt, 19);
        @(negedge clk);
        check("ill_err_pulse", bus.err, 0);

        // XNOR with start and a=1111 held during busy, then back-to-back NOT in done cycle.
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.a     = 4'b0011;
        bus.b     = 4'b0101;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!bus.done && lat < 12) begin
            bus.start = 1'b1;
            bus.op    = 3'd0;
            bus.a     = 4'hF;
            @(negedge clk);
            lat++;
        end
        check("hold_lat", lat, 5);
        check("hold_y", bus.y, 4'b1001);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", bus.busy, 1);
        check("b2b_done", bus.done, 0);
        @(negedge clk);
        check("b2b_done2", bus.done, 1);
        check("b2b_y", bus.y, 4'b0000);
        check("b2b_cnt", bus.nand_cnt, 25);
        @(negedge clk);

        // Saturating counter.
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        run_op(3'd1, 4'b0011, 4'b0101, lat);
        check("sat_y", bus.y, 4'b0001);
        check("sat_cnt", bus.nand_cnt, 16'hFFFF);
        @(negedge clk);
        run_op(3'd1, 4'b0011, 4'b0101, lat);
        check("sat_hold", bus.nand_cnt, 16'hFFFF);
        @(negedge clk);

        // Reset in the middle of XOR.
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.a     = 4'b0011;
        bus.b     = 4'b0101;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", bus.busy, 0);
        check("mrst_done", bus.done, 0);
        check("mrst_err", bus.err, 0);
        check("mrst_y", bus.y, 0);
        check("mrst_cnt", bus.nand_cnt, 0);
        rst    = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("mrst_no_done", pulses, 0);

        // Exhaustive sweep against the gate-level reference.
        for (int o = 0; o < 6; o++) begin
            for (int v = 0; v < 256; v++) begin
                logic [7:0] ab;
                ab = 8'(v);
                run_op(3'(o), ab[7:4], ab[3:0], lat);
                check($sformatf("sw_op%0d_%02h_y", o, v), bus.y, ref_op(3'(o), ab[7:4], ab[3:0]));
                check($sformatf("sw_op%0d_%02h_lat", o, v), lat, exp_lat[o]);
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
